// File: rtl/uart_word_tx.sv
// UART word serialiser: one multi-byte word per valid/ready handshake,
// sent as back-to-back 8-bit frames with optional parity and 1/2 stop bits.
module uart_word_tx #(
    parameter int CLK_FRE    = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int WORD_BYTES = 4,
    parameter int MSB_FIRST  = 1,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*WORD_BYTES-1:0] data_in,
    output logic                    tx,
    output logic                    busy,
    output logic                    word_done
);

    localparam int BIT_TICKS = CLK_FRE / BAUD_RATE;
    localparam int DW = 8 * WORD_BYTES;
    localparam int TW = (BIT_TICKS > 2) ? $clog2(BIT_TICKS) : 1;
    localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(BIT_TICKS - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(WORD_BYTES - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    generate
        if (BIT_TICKS < 2) begin : g_bad_baud
            $error("uart_word_tx: CLK_FRE/BAUD_RATE must be >= 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_word_tx: STOP_BITS must be 1 or 2");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_par
            $error("uart_word_tx: PARITY must be 0, 1 or 2");
        end
        if (WORD_BYTES < 1 || WORD_BYTES > 16) begin : g_bad_bytes
            $error("uart_word_tx: WORD_BYTES must be 1..16");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t          state_q, state_n;
    logic [TW-1:0]   tick_q, tick_n;
    logic [2:0]      bit_q, bit_n;
    logic [BW-1:0]   byte_q, byte_n;
    logic [DW-1:0]   shreg_q, shreg_n;
    logic            tx_q, tx_n;
    logic            done_q, done_n;
    logic            busy_q;
    logic            rdy_q;

    logic [7:0]      cur_byte;
    logic [DW-1:0]   shreg_adv;
    logic            par_bit;
    logic            tick_wrap;

    // The byte on the send end of the shift register is always the current one.
    assign cur_byte  = (MSB_FIRST != 0) ? shreg_q[DW-1 -: 8] : shreg_q[7:0];
    assign shreg_adv = (MSB_FIRST != 0) ? (shreg_q << 8) : (shreg_q >> 8);
    assign par_bit   = (PARITY == 2) ? ~(^cur_byte) : (^cur_byte);
    assign tick_wrap = (tick_q == LAST_TICK);

    always_comb begin
        state_n = state_q;
        tick_n  = tick_q;
        bit_n   = bit_q;
        byte_n  = byte_q;
        shreg_n = shreg_q;
        tx_n    = tx_q;
        done_n  = 1'b0;
        if (state_q != S_IDLE) begin
            tick_n = tick_wrap ? '0 : tick_q + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                tx_n   = 1'b1;
                tick_n = '0;
                if (in_valid && rdy_q) begin
                    state_n = S_START;
                    shreg_n = data_in;
                    byte_n  = '0;
                    bit_n   = '0;
                    tx_n    = 1'b0;
                end
            end
            S_START: begin
                if (tick_wrap) begin
                    state_n = S_DATA;
                    bit_n   = '0;
                    tx_n    = cur_byte[0];
                end
            end
            S_DATA: begin
                if (tick_wrap) begin
                    if (bit_q == 3'd7) begin
                        bit_n = '0;
                        if (PARITY != 0) begin
                            state_n = S_PARITY;
                            tx_n    = par_bit;
                        end else begin
                            state_n = S_STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_n = bit_q + 3'd1;
                        tx_n  = cur_byte[bit_q + 3'd1];
                    end
                end
            end
            S_PARITY: begin
                if (tick_wrap) begin
                    state_n = S_STOP;
                    bit_n   = '0;
                    tx_n    = 1'b1;
                end
            end
            S_STOP: begin
                if (tick_wrap) begin
                    if (bit_q == LAST_STOP) begin
                        bit_n = '0;
                        if (byte_q != LAST_BYTE) begin
                            state_n = S_START;
                            byte_n  = byte_q + 1'b1;
                            shreg_n = shreg_adv;
                            tx_n    = 1'b0;
                        end else begin
                            state_n = S_IDLE;
                            tx_n    = 1'b1;
                            done_n  = 1'b1;
                        end
                    end else begin
                        bit_n = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            tick_q  <= tick_n;
            bit_q   <= bit_n;
            byte_q  <= byte_n;
            shreg_q <= shreg_n;
            tx_q    <= tx_n;
            done_q  <= done_n;
            busy_q  <= (state_n != S_IDLE);
            rdy_q   <= (state_n == S_IDLE);
        end
    end

    assign tx        = tx_q;
    assign busy      = busy_q;
    assign in_ready  = rdy_q;
    assign word_done = done_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: four parameterisations, table-driven words
// plus back-to-back and mid-frame reset sequences.
module tb_uart_word_tx;

    logic        clk;
    logic        rst;
    logic        vld  [4];
    logic [31:0] din  [4];
    logic        rdy  [4];
    logic        txl  [4];
    logic        bsy  [4];
    logic        done [4];

    int checks;
    int errors;

    int nw [4] = '{4, 4, 1, 1};
    int pm [4] = '{0, 0, 1, 2};
    int sb [4] = '{1, 1, 2, 1};

    typedef struct {
        int          dut;
        logic [31:0] word;
        logic [31:0] exp;
        logic        exp_par;
        bit          toggle;
    } vec_t;

    vec_t vecs [10];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_word_tx #(.CLK_FRE(160), .BAUD_RATE(10), .WORD_BYTES(4),
                   .MSB_FIRST(1), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(rdy[0]),
        .data_in(din[0]), .tx(txl[0]), .busy(bsy[0]), .word_done(done[0]));

    uart_word_tx #(.CLK_FRE(160), .BAUD_RATE(10), .WORD_BYTES(4),
                   .MSB_FIRST(0), .PARITY(0), .STOP_BITS(1)) u_b (
        .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(rdy[1]),
        .data_in(din[1]), .tx(txl[1]), .busy(bsy[1]), .word_done(done[1]));

    uart_word_tx #(.CLK_FRE(160), .BAUD_RATE(10), .WORD_BYTES(1),
                   .MSB_FIRST(1), .PARITY(1), .STOP_BITS(2)) u_c (
        .clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(rdy[2]),
        .data_in(din[2][7:0]), .tx(txl[2]), .busy(bsy[2]), .word_done(done[2]));

    uart_word_tx #(.CLK_FRE(160), .BAUD_RATE(10), .WORD_BYTES(1),
                   .MSB_FIRST(1), .PARITY(2), .STOP_BITS(1)) u_d (
        .clk(clk), .rst(rst), .in_valid(vld[3]), .in_ready(rdy[3]),
        .data_in(din[3][7:0]), .tx(txl[3]), .busy(bsy[3]), .word_done(done[3]));

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input int i, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (rdy[i] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk($sformatf("ready_wait_dut%0d", i), 32'(ok), 32'd1);
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int          i;
        int          nb;
        int          wl;
        int          first_done;
        int          done_cnt;
        int          width_err;
        int          rdy_err;
        int          frame_err;
        bit          ok;
        logic        bits  [48];
        logic        early [48];
        logic [31:0] got;
        logic [7:0]  by;
        i  = v.dut;
        nb = 10 + ((pm[i] != 0) ? 1 : 0) + (sb[i] - 1);
        wl = nw[i] * nb * 16;
        first_done = -1;
        done_cnt = 0;
        width_err = 0;
        rdy_err = 0;
        frame_err = 0;
        got = '0;
        wait_ready(i, ok);
        if (!ok) return;
        din[i] = v.word;
        vld[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld[i] = 1'b0;
        chk($sformatf("v%0d_busy_at_accept", n), 32'(bsy[i]), 32'd1);
        for (int pos = 0; pos < wl + 4; pos++) begin
            if (pos > 0) @(negedge clk);
            if (pos < wl) begin
                int ph;
                int bi;
                ph = pos % 16;
                bi = pos / 16;
                if (ph == 0) early[bi] = txl[i];
                if (ph == 8) bits[bi] = txl[i];
                if (ph == 15 && (txl[i] !== bits[bi] || early[bi] !== bits[bi]))
                    width_err++;
                if (rdy[i] !== 1'b0) rdy_err++;
            end
            if (done[i] === 1'b1) begin
                done_cnt++;
                if (first_done < 0) first_done = pos;
            end
            if (v.toggle) din[i] = ~din[i];
        end
        for (int b = 0; b < nw[i]; b++) begin
            if (bits[b*nb] !== 1'b0) frame_err++;
            for (int j = 0; j < 8; j++) by[j] = bits[b*nb + 1 + j];
            got = {got[23:0], by};
            if (pm[i] != 0)
                chk($sformatf("v%0d_parity", n), 32'(bits[b*nb + 9]),
                    32'(v.exp_par));
            for (int s = 0; s < sb[i]; s++)
                if (bits[b*nb + nb - 1 - s] !== 1'b1) frame_err++;
        end
        chk($sformatf("v%0d_bytes", n), got, v.exp);
        chk($sformatf("v%0d_frame_bits", n), 32'(frame_err), 32'd0);
        chk($sformatf("v%0d_bit_width", n), 32'(width_err), 32'd0);
        chk($sformatf("v%0d_ready_low", n), 32'(rdy_err), 32'd0);
        chk($sformatf("v%0d_done_latency", n), 32'(first_done), 32'(wl));
        chk($sformatf("v%0d_done_pulses", n), 32'(done_cnt), 32'd1);
        chk($sformatf("v%0d_idle_after", n),
            {30'd0, bsy[i], rdy[i]}, 32'd1);
        din[i] = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        bit ok;
        int first_done;
        int second_done;
        int rdy_err;
        int idle_err;
        checks = 0;
        errors = 0;
        vecs[0] = '{0, 32'h11223344, 32'h11223344, 1'b0, 1'b0};
        vecs[1] = '{1, 32'h11223344, 32'h44332211, 1'b0, 1'b0};
        vecs[2] = '{2, 32'h000000A7, 32'h000000A7, 1'b1, 1'b0};
        vecs[3] = '{3, 32'h000000A7, 32'h000000A7, 1'b0, 1'b0};
        vecs[4] = '{2, 32'h00000000, 32'h00000000, 1'b0, 1'b0};
        vecs[5] = '{3, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
        vecs[6] = '{2, 32'h00000001, 32'h00000001, 1'b1, 1'b0};
        vecs[7] = '{3, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
        vecs[8] = '{0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1};
        vecs[9] = '{1, 32'h0000FFFF, 32'hFFFF0000, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            vld[i] = 1'b0;
            din[i] = '0;
        end
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++)
            chk($sformatf("reset_state_dut%0d", i),
                {28'd0, txl[i], rdy[i], bsy[i], done[i]}, 32'h8);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            chk($sformatf("ready_after_release_dut%0d", i),
                {31'd0, rdy[i]}, 32'd1);

        for (int n = 0; n < 10; n++) run_vec(n, vecs[n]);

        // back-to-back words with in_valid held high
        wait_ready(0, ok);
        din[0] = 32'h11223344;
        vld[0] = 1'b1;
        @(posedge clk);
        first_done = -1;
        second_done = -1;
        rdy_err = 0;
        for (int pos = 0; pos < 1300; pos++) begin
            @(negedge clk);
            if (pos == 0) din[0] = 32'hCAFEF00D;
            if (pos < 640 && rdy[0] !== 1'b0) rdy_err++;
            if (done[0] === 1'b1) begin
                if (first_done < 0) first_done = pos;
                else if (second_done < 0) second_done = pos;
            end
            if (pos == 640)
                chk("b2b_line_high_at_done", {30'd0, txl[0], rdy[0]}, 32'h3);
            if (pos == 641) begin
                chk("b2b_second_start", {30'd0, txl[0], bsy[0]}, 32'h1);
                vld[0] = 1'b0;
            end
        end
        chk("b2b_ready_low_first", 32'(rdy_err), 32'd0);
        chk("b2b_first_done", 32'(first_done), 32'd640);
        chk("b2b_second_done", 32'(second_done), 32'd1281);

        // asynchronous reset in the middle of a word
        wait_ready(0, ok);
        din[0] = 32'h5A5A5A5A;
        vld[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (100) @(negedge clk);
        chk("pre_reset_tx_low", {31'd0, txl[0]}, 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_outputs", {29'd0, txl[0], bsy[0], rdy[0]}, 32'h4);
        @(negedge clk);
        rst = 1'b1;
        idle_err = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (txl[0] !== 1'b1 || bsy[0] !== 1'b0 || done[0] !== 1'b0)
                idle_err++;
        end
        chk("post_reset_quiet", 32'(idle_err), 32'd0);
        chk("post_reset_ready", {31'd0, rdy[0]}, 32'd1);
        run_vec(10, vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
